// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: two-entry skid buffer between decode and execute.
// Ports: clk, reset (sync, active-high), flush, in_valid/in_ready,
//   RD1/RD2/IMM/DataSource/ALUOp/WriteSelect/WriteEnable _IN and _OUT,
//   out_valid/out_ready. Optional STAGE_PERF_CNT_EN adds stall_cnt,
//   bubble_cnt, flush_cnt (32-bit saturating event counters).
module id_ex_skid_stage #(
   parameter int DATA_W     = 32,
   parameter int IMM_W      = 16,
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     RD1_IN,
   input  logic [DATA_W-1:0]     RD2_IN,
   input  logic [IMM_W-1:0]      IMM_IN,
   input  logic                  DataSource_IN,
   input  logic [ALUOP_W-1:0]    ALUOp_IN,
   input  logic [REG_ADDR_W-1:0] WriteSelect_IN,
   input  logic                  WriteEnable_IN,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     RD1_OUT,
   output logic [DATA_W-1:0]     RD2_OUT,
   output logic [IMM_W-1:0]      IMM_OUT,
   output logic                  DataSource_OUT,
   output logic [ALUOP_W-1:0]    ALUOp_OUT,
   output logic [REG_ADDR_W-1:0] WriteSelect_OUT,
   output logic                  WriteEnable_OUT
`ifdef STAGE_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           bubble_cnt,
   output logic [31:0]           flush_cnt
`endif
);

   typedef struct packed {
      logic [DATA_W-1:0]     rd1;
      logic [DATA_W-1:0]     rd2;
      logic [IMM_W-1:0]      imm;
      logic                  ds;
      logic [ALUOP_W-1:0]    aluop;
      logic [REG_ADDR_W-1:0] ws;
      logic                  we;
   } bundle_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t  state, state_n;
   bundle_t main_q, skid_q, in_b;
   logic    rdy_q;
   logic    in_xfer, out_xfer;
   logic    load_main, load_skid, skid_mv;

   assign in_b = '{
      rd1:   RD1_IN,
      rd2:   RD2_IN,
      imm:   IMM_IN,
      ds:    DataSource_IN,
      aluop: ALUOp_IN,
      ws:    WriteSelect_IN,
      we:    WriteEnable_IN
   };

   // Ready is registered; the reset gate keeps it low while reset is
   // held, yet the register itself resets to 1 so the stage accepts
   // in the very first cycle after release.
   assign in_ready  = rdy_q & ~reset;
   assign out_valid = (state != EMPTY);
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   always_comb begin
      state_n   = state;
      load_main = 1'b0;
      load_skid = 1'b0;
      skid_mv   = 1'b0;
      unique case (state)
         EMPTY: begin
            if (in_xfer) begin
               load_main = 1'b1;
               state_n   = ONE;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               load_main = 1'b1;
            end else if (in_xfer) begin
               load_skid = 1'b1;
               state_n   = TWO;
            end else if (out_xfer) begin
               state_n   = EMPTY;
            end
         end
         TWO: begin
            if (out_xfer) begin
               skid_mv = 1'b1;
               state_n = ONE;
            end
         end
         default: state_n = EMPTY;
      endcase
      // Flush discards held entries and any bundle arriving this cycle.
      if (flush) begin
         state_n   = EMPTY;
         load_main = 1'b0;
         load_skid = 1'b0;
         skid_mv   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= EMPTY;
         rdy_q  <= 1'b1;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= state_n;
         rdy_q <= (state_n != TWO);
         if (load_main) begin
            main_q <= in_b;
         end else if (skid_mv) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_b;
         end
      end
   end

   assign RD1_OUT         = main_q.rd1;
   assign RD2_OUT         = main_q.rd2;
   assign IMM_OUT         = main_q.imm;
   assign DataSource_OUT  = main_q.ds;
   assign ALUOp_OUT       = main_q.aluop;
   assign WriteSelect_OUT = main_q.ws;
   // A bubble must never write the register file.
   assign WriteEnable_OUT = main_q.we & out_valid;

`ifdef STAGE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (!out_valid && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
         if (flush && flush_cnt != '1) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// tb_id_ex_skid_stage: directed bench for id_ex_skid_stage.
// Covers reset, streaming, back-pressure, flush, reset-over-flush.
module tb_id_ex_skid_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] RD1_IN, RD2_IN;
   logic [15:0] IMM_IN;
   logic        DataSource_IN;
   logic [2:0]  ALUOp_IN;
   logic [4:0]  WriteSelect_IN;
   logic        WriteEnable_IN;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] RD1_OUT, RD2_OUT;
   logic [15:0] IMM_OUT;
   logic        DataSource_OUT;
   logic [2:0]  ALUOp_OUT;
   logic [4:0]  WriteSelect_OUT;
   logic        WriteEnable_OUT;
`ifdef STAGE_PERF_CNT_EN
   logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
   logic [31:0] snap;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   id_ex_skid_stage dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .RD1_IN          (RD1_IN),
      .RD2_IN          (RD2_IN),
      .IMM_IN          (IMM_IN),
      .DataSource_IN   (DataSource_IN),
      .ALUOp_IN        (ALUOp_IN),
      .WriteSelect_IN  (WriteSelect_IN),
      .WriteEnable_IN  (WriteEnable_IN),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .RD1_OUT         (RD1_OUT),
      .RD2_OUT         (RD2_OUT),
      .IMM_OUT         (IMM_OUT),
      .DataSource_OUT  (DataSource_OUT),
      .ALUOp_OUT       (ALUOp_OUT),
      .WriteSelect_OUT (WriteSelect_OUT),
      .WriteEnable_OUT (WriteEnable_OUT)
`ifdef STAGE_PERF_CNT_EN
      ,
      .stall_cnt       (stall_cnt),
      .bubble_cnt      (bubble_cnt),
      .flush_cnt       (flush_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;  flush = 1'b0;
      in_valid = 1'b0;  out_ready = 1'b0;
      RD1_IN = '0;  RD2_IN = '0;  IMM_IN = '0;
      DataSource_IN = 1'b0;  ALUOp_IN = '0;
      WriteSelect_IN = '0;  WriteEnable_IN = 1'b0;

      // Reset held two cycles
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_rd1", RD1_OUT, 32'd0);
      chk("rst_we", 32'(WriteEnable_OUT), 32'd0);
      chk("rst_ws", 32'(WriteSelect_OUT), 32'd0);
      reset = 1'b0;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      chk("rel_out_valid", 32'(out_valid), 32'd0);

      // Streaming 1..4
      in_valid = 1'b1;  out_ready = 1'b1;
      WriteEnable_IN = 1'b1;  WriteSelect_IN = 5'd1;
      for (int i = 1; i <= 4; i++) begin
         RD1_IN = 32'(i);
         tick();
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_rd1", RD1_OUT, 32'(i));
         chk("stream_rdy", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("drain_valid", 32'(out_valid), 32'd0);
      chk("drain_we", 32'(WriteEnable_OUT), 32'd0);

      // Back-pressure: A then B
      out_ready = 1'b0;  in_valid = 1'b1;
      RD1_IN = 32'hA;  RD2_IN = 32'h1A;  IMM_IN = 16'h2A;
      DataSource_IN = 1'b1;  ALUOp_IN = 3'd3;  WriteSelect_IN = 5'd7;
      tick();
      chk("bp_a_valid", 32'(out_valid), 32'd1);
      chk("bp_a_rdy", 32'(in_ready), 32'd1);
      RD1_IN = 32'hB;  RD2_IN = 32'h1B;  IMM_IN = 16'h2B;
      DataSource_IN = 1'b0;  ALUOp_IN = 3'd5;  WriteSelect_IN = 5'd9;
      tick();
      chk("bp_two_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold_rd1", RD1_OUT, 32'hA);
      in_valid = 1'b0;
      tick();
      chk("bp_hold2_rd1", RD1_OUT, 32'hA);
      chk("bp_hold_rd2", RD2_OUT, 32'h1A);
      chk("bp_hold_imm", 32'(IMM_OUT), 32'h2A);
      chk("bp_hold_ds", 32'(DataSource_OUT), 32'd1);
      chk("bp_hold_alu", 32'(ALUOp_OUT), 32'd3);
      chk("bp_hold_ws", 32'(WriteSelect_OUT), 32'd7);
      chk("bp_hold_we", 32'(WriteEnable_OUT), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("bp_b_rd1", RD1_OUT, 32'hB);
      chk("bp_b_alu", 32'(ALUOp_OUT), 32'd5);
      chk("bp_b_valid", 32'(out_valid), 32'd1);
      chk("bp_b_rdy", 32'(in_ready), 32'd1);
      tick();
      chk("bp_end_valid", 32'(out_valid), 32'd0);

      // Flush in TWO with incoming 0xC
      out_ready = 1'b0;  in_valid = 1'b1;  RD1_IN = 32'hA;
      tick();
      RD1_IN = 32'hB;
      tick();
      chk("fl_pre_rdy", 32'(in_ready), 32'd0);
      flush = 1'b1;  RD1_IN = 32'hC;
      tick();
      chk("fl_valid", 32'(out_valid), 32'd0);
      chk("fl_we", 32'(WriteEnable_OUT), 32'd0);
      chk("fl_rdy", 32'(in_ready), 32'd1);
      flush = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fl_no_c", 32'(out_valid), 32'd0);
      end

      // Flush in ONE with a simultaneous accepted input 0xD
      out_ready = 1'b0;  in_valid = 1'b1;  RD1_IN = 32'h9;
      tick();
      flush = 1'b1;  RD1_IN = 32'hD;
      tick();
      chk("fl1_valid", 32'(out_valid), 32'd0);
      flush = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
      tick();
      chk("fl1_no_d", 32'(out_valid), 32'd0);

      // Reset overrides flush while in TWO
      out_ready = 1'b0;  in_valid = 1'b1;  RD1_IN = 32'hE;
      tick();
      RD1_IN = 32'hF;
      tick();
      chk("rs_pre_rdy", 32'(in_ready), 32'd0);
      reset = 1'b1;  flush = 1'b1;  in_valid = 1'b0;
      tick();
      chk("rs_valid", 32'(out_valid), 32'd0);
      chk("rs_rdy", 32'(in_ready), 32'd0);
      chk("rs_rd1", RD1_OUT, 32'd0);
      chk("rs_we", 32'(WriteEnable_OUT), 32'd0);
      chk("rs_alu", 32'(ALUOp_OUT), 32'd0);
      reset = 1'b0;  flush = 1'b0;  out_ready = 1'b1;
      #1;
      chk("rs_rel_rdy", 32'(in_ready), 32'd1);
      tick();
      chk("rs_no_resid", 32'(out_valid), 32'd0);
      in_valid = 1'b1;  RD1_IN = 32'h5;
      tick();
      chk("rs_recov_rd1", RD1_OUT, 32'h5);
      chk("rs_recov_vld", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      tick();
      chk("rs_recov_end", 32'(out_valid), 32'd0);

`ifdef STAGE_PERF_CNT_EN
      // Perf counters: 5 stalled cycles, 3 flush pulses
      out_ready = 1'b0;  in_valid = 1'b1;  RD1_IN = 32'h6;
      tick();
      in_valid = 1'b0;
      snap = stall_cnt;
      for (int i = 0; i < 5; i++) tick();
      chk("pc_stall", stall_cnt - snap, 32'd5);
      snap = flush_cnt;
      for (int i = 0; i < 3; i++) begin
         flush = 1'b1;
         tick();
         flush = 1'b0;
         tick();
      end
      chk("pc_flush", flush_cnt - snap, 32'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
